// File: rtl/fsm_clear_checker.sv
// rtl/fsm_clear_checker.sv - run-time checker for "a==0 |=> ##[MIN_DLY:MAX_DLY] y==0"
module fsm_clear_checker #(
   parameter int MIN_DLY = 1,
   parameter int MAX_DLY = 4,
   parameter int CNT_W   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_a,
   input  logic             i_y,
   input  logic             i_clr_sticky,
   output logic             o_viol_pulse,
   output logic             o_viol_sticky,
   output logic [CNT_W-1:0] o_viol_count,
   output logic             o_cover_hit,
   output logic             o_pending
);

   // pend[j] tracks an obligation created j enabled edges ago; pend[D] is its last chance.
   localparam int D = MAX_DLY + 1;

   logic [D:1]       r_pend;
   logic [D:1]       w_pend_nxt;
   logic [D:1]       w_clr;
   logic             w_fail;
   logic             r_viol_pulse;
   logic             r_viol_sticky;
   logic [CNT_W-1:0] r_viol_count;
   logic             r_cover_hit;

   // Discharge eligible obligations on y==0, flag the oldest one if y is still 1, age the rest.
   always_comb begin
      w_clr      = '0;
      w_pend_nxt = '0;
      w_fail     = r_pend[D] & i_y;
      for (int j = 1; j <= D; j++) begin
         if (j >= MIN_DLY + 1) begin
            w_clr[j] = r_pend[j] & ~i_y;
         end
      end
      w_pend_nxt[1] = ~i_a;
      for (int j = 1; j < D; j++) begin
         w_pend_nxt[j+1] = r_pend[j] & ~w_clr[j];
      end
   end

   // Obligation vector and registered reporting; a disabled cycle freezes everything but the pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend        <= '0;
         r_viol_pulse  <= 1'b0;
         r_viol_sticky <= 1'b0;
         r_viol_count  <= '0;
         r_cover_hit   <= 1'b0;
      end else if (i_en) begin
         r_pend        <= w_pend_nxt;
         r_viol_pulse  <= w_fail;
         r_viol_sticky <= (r_viol_sticky & ~i_clr_sticky) | w_fail;
         r_cover_hit   <= (r_cover_hit & ~i_clr_sticky) | i_y;
         if (w_fail && (r_viol_count != {CNT_W{1'b1}})) begin
            r_viol_count <= r_viol_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         r_viol_pulse <= 1'b0;
      end
   end

   assign o_viol_pulse  = r_viol_pulse;
   assign o_viol_sticky = r_viol_sticky;
   assign o_viol_count  = r_viol_count;
   assign o_cover_hit   = r_cover_hit;
   assign o_pending     = |r_pend;

endmodule

// File: tb/tb_fsm_clear_checker.sv
// tb/tb_fsm_clear_checker.sv - self-checking bench for fsm_clear_checker
module tb_fsm_clear_checker;

   localparam int MIN_DLY = 1;
   localparam int MAX_DLY = 4;
   localparam int CNT_W   = 8;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_en = 1'b0;
   logic             i_a = 1'b1;
   logic             i_y = 1'b0;
   logic             i_clr_sticky = 1'b0;
   logic             o_viol_pulse;
   logic             o_viol_sticky;
   logic [CNT_W-1:0] o_viol_count;
   logic             o_cover_hit;
   logic             o_pending;

   fsm_clear_checker #(.MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_a(i_a), .i_y(i_y),
      .i_clr_sticky(i_clr_sticky), .o_viol_pulse(o_viol_pulse),
      .o_viol_sticky(o_viol_sticky), .o_viol_count(o_viol_count),
      .o_cover_hit(o_cover_hit), .o_pending(o_pending)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;
   int last_pulse = -1;
   bit pulse_seen = 0;

   // model: creation times (in enabled-edge units) of outstanding obligations
   int q[$];
   int n = 0;
   bit m_pulse = 0, m_sticky = 0, m_cover = 0;
   int m_count = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_no, act, exp);
      end
   endtask

   task automatic model_edge(input bit a, input bit y, input bit en, input bit clr, input bit rst);
      int nq[$];
      bit fail;
      int age;
      if (rst) begin
         q.delete();
         n = 0;
         m_pulse = 0; m_sticky = 0; m_count = 0; m_cover = 0;
      end else if (en) begin
         fail = 0;
         foreach (q[i]) begin
            age = n - q[i];
            if (age == MAX_DLY + 1) begin
               if (y) fail = 1;
            end else if (!(age >= MIN_DLY + 1 && !y)) begin
               nq.push_back(q[i]);
            end
         end
         q = nq;
         if (!a) q.push_back(n);
         n++;
         m_pulse  = fail;
         m_sticky = (m_sticky && !clr) || fail;
         m_cover  = (m_cover && !clr) || y;
         if (fail && m_count < CMAX) m_count++;
      end else begin
         m_pulse = 0;
      end
   endtask

   task automatic compare_all();
      chk("viol_pulse", int'(o_viol_pulse), int'(m_pulse));
      chk("viol_sticky", int'(o_viol_sticky), int'(m_sticky));
      chk("viol_count", int'(o_viol_count), m_count);
      chk("cover_hit", int'(o_cover_hit), int'(m_cover));
      chk("pending", int'(o_pending), int'(q.size() != 0));
   endtask

   task automatic step(input bit a, input bit y, input bit en, input bit clr, input bit rst);
      @(negedge i_clk);
      i_a = a; i_y = y; i_en = en; i_clr_sticky = clr; i_rst = rst;
      @(posedge i_clk);
      edge_no++;
      model_edge(a, y, en, clr, rst);
      #1;
      compare_all();
      if (o_viol_pulse === 1'b1) begin
         last_pulse = edge_no;
         pulse_seen = 1;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 1, 1, 0, 0);
   endtask

   int e0;

   initial begin
      // reset state
      step(1, 0, 1, 0, 1);
      step(1, 0, 1, 0, 1);
      chk("rst_pending", int'(o_pending), 0);
      chk("rst_count", int'(o_viol_count), 0);
      chk("rst_cover", int'(o_cover_hit), 0);

      // test 1: a=0,y=0 constantly
      pulse_seen = 0;
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
      chk("t1_count", int'(o_viol_count), 0);
      chk("t1_cover", int'(o_cover_hit), 0);
      chk("t1_no_pulse", int'(pulse_seen), 0);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);

      // test 2: single a=0, y=1 throughout
      step(0, 1, 1, 0, 0);
      e0 = edge_no;
      idle(8);
      chk("t2_pulse_edge", last_pulse - e0, 5);
      chk("t2_count", int'(o_viol_count), 1);
      chk("t2_sticky", int'(o_viol_sticky), 1);

      // test 3: y=0 at a single offset only
      for (int o = 0; o < 7; o++) step(o != 0, o != 1, 1, 0, 0);
      idle(6);
      chk("t3_early", int'(o_viol_count), 2);
      for (int o = 0; o < 7; o++) step(o != 0, o != 2, 1, 0, 0);
      idle(6);
      chk("t3_first_ok", int'(o_viol_count), 2);
      for (int o = 0; o < 7; o++) step(o != 0, o != 5, 1, 0, 0);
      idle(6);
      chk("t3_last_ok", int'(o_viol_count), 2);

      // test 4: 10 consecutive a=0, y stuck 1
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
      idle(8);
      chk("t4_count", int'(o_viol_count), 12);

      // test 6a: reset mid-window discards the obligation
      step(0, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 1, 0, 1);
      chk("t6_pending_after_rst", int'(o_pending), 0);
      pulse_seen = 0;
      idle(8);
      chk("t6_no_pulse", int'(pulse_seen), 0);
      chk("t6_count", int'(o_viol_count), 0);

      // test 6b: en=0 for 8 cycles defers the deadline by 8
      step(0, 1, 1, 0, 0);
      e0 = edge_no;
      for (int i = 0; i < 8; i++) step($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
      idle(8);
      chk("t6_deferred_edge", last_pulse - e0, 13);
      chk("t6_deferred_count", int'(o_viol_count), 1);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 199) == 0);
      end

      // test 5: saturation and clr_sticky racing a fail
      step(1, 1, 1, 0, 1);
      for (int i = 0; i < CMAX + 20; i++) step(0, 1, 1, 0, 0);
      chk("t5_saturated", int'(o_viol_count), CMAX);
      step(0, 1, 1, 1, 0);
      chk("t5_set_wins_sticky", int'(o_viol_sticky), 1);
      chk("t5_set_wins_cover", int'(o_cover_hit), 1);
      step(1, 0, 1, 1, 0);
      step(1, 0, 1, 1, 0);
      chk("t5_cleared_sticky", int'(o_viol_sticky), 0);
      chk("t5_cleared_cover", int'(o_cover_hit), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
